// File: rtl/hub75_bcm_scan.sv
// Row/bit-plane sequencer for a HUB75 panel: asks the shifter for one plane of row data,
// latches it once the previous display period ends, then starts the BCM-weighted display.
module hub75_bcm_scan #(
  parameter int N_ROWS   = 32,
  parameter int N_PLANES = 8,
  localparam int LOG_N_ROWS = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int PLANE_W    = (N_PLANES > 1) ? $clog2(N_PLANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [LOG_N_ROWS-1:0] phy_addr,
  output logic                  phy_le,
  output logic                  shift_go,
  output logic [LOG_N_ROWS-1:0] shift_row,
  output logic [PLANE_W-1:0]    shift_plane,
  input  logic                  shift_rdy,
  output logic                  blank_go,
  output logic [N_PLANES-1:0]   blank_plane,
  input  logic                  blank_rdy,
  input  logic                  enable,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_GO,
    S_SHIFT_WAIT,
    S_BLANK_WAIT,
    S_LATCH,
    S_BLANK_GO
  } state_t;

  state_t                state_q;
  logic [LOG_N_ROWS-1:0] nxt_row_q, nxt_row_d, cur_row_q, phy_addr_q;
  logic [PLANE_W-1:0]    nxt_plane_q, nxt_plane_d, cur_plane_q;
  logic                  shift_go_q, blank_go_q, phy_le_q, frame_done_q;
  logic [N_PLANES-1:0]   blank_plane_q;
  logic                  last_job;

  // Job order: every plane of a row, then the next row, wrapping at the bottom of the panel.
  always_comb begin
    nxt_plane_d = nxt_plane_q + 1'b1;
    nxt_row_d   = nxt_row_q;
    if (nxt_plane_q == PLANE_W'(N_PLANES - 1)) begin
      nxt_plane_d = '0;
      nxt_row_d   = (nxt_row_q == LOG_N_ROWS'(N_ROWS - 1)) ? '0 : nxt_row_q + 1'b1;
    end
  end

  assign last_job = (cur_row_q == LOG_N_ROWS'(N_ROWS - 1)) &&
                    (cur_plane_q == PLANE_W'(N_PLANES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      nxt_row_q     <= '0;
      nxt_plane_q   <= '0;
      cur_row_q     <= '0;
      cur_plane_q   <= '0;
      phy_addr_q    <= '0;
      phy_le_q      <= 1'b0;
      shift_go_q    <= 1'b0;
      blank_go_q    <= 1'b0;
      blank_plane_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            shift_go_q <= 1'b1;
            state_q    <= S_SHIFT_GO;
          end
        end
        S_SHIFT_GO: begin
          if (shift_rdy) begin
            cur_row_q   <= nxt_row_q;
            cur_plane_q <= nxt_plane_q;
            nxt_row_q   <= nxt_row_d;
            nxt_plane_q <= nxt_plane_d;
            shift_go_q  <= 1'b0;
            state_q     <= S_SHIFT_WAIT;
          end
        end
        S_SHIFT_WAIT: begin
          if (shift_rdy) state_q <= S_BLANK_WAIT;
        end
        // blank_rdy high means the previous display period is over and the panel is dark.
        S_BLANK_WAIT: begin
          if (blank_rdy) begin
            phy_le_q   <= 1'b1;
            phy_addr_q <= cur_row_q;
            state_q    <= S_LATCH;
          end
        end
        S_LATCH: begin
          phy_le_q      <= 1'b0;
          blank_go_q    <= 1'b1;
          blank_plane_q <= N_PLANES'(1) << cur_plane_q;
          state_q       <= S_BLANK_GO;
        end
        S_BLANK_GO: begin
          if (blank_rdy) begin
            blank_go_q    <= 1'b0;
            blank_plane_q <= '0;
            frame_done_q  <= last_job;
            if (enable) begin
              shift_go_q <= 1'b1;
              state_q    <= S_SHIFT_GO;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // shift_row/shift_plane are only meaningful while shift_go is high.
  assign shift_row   = nxt_row_q;
  assign shift_plane = nxt_plane_q;
  assign phy_addr    = phy_addr_q;
  assign phy_le      = phy_le_q;
  assign shift_go    = shift_go_q;
  assign blank_go    = blank_go_q;
  assign blank_plane = blank_plane_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan: shift/blank responder models plus a job-index scoreboard
// that derives each expected (row, plane) from the transfer count.
module tb_hub75_bcm_scan;
  localparam int NR = 4;
  localparam int NP = 2;
  localparam int NJ = NR * NP;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] phy_addr;
  logic       phy_le;
  logic       shift_go;
  logic [1:0] shift_row;
  logic [0:0] shift_plane;
  logic       shift_rdy;
  logic       blank_go;
  logic [1:0] blank_plane;
  logic       blank_rdy;
  logic       frame_done;

  hub75_bcm_scan #(.N_ROWS(NR), .N_PLANES(NP)) dut (
    .clk(clk), .rst_n(rst_n), .phy_addr(phy_addr), .phy_le(phy_le),
    .shift_go(shift_go), .shift_row(shift_row), .shift_plane(shift_plane),
    .shift_rdy(shift_rdy), .blank_go(blank_go), .blank_plane(blank_plane),
    .blank_rdy(blank_rdy), .enable(enable), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Responders: rdy drops the cycle after a transfer and stays low for *_busy cycles.
  int sh_busy = 3, bl_busy = 3;
  int sh_cnt = 0, bl_cnt = 0;
  bit sh_hold = 1'b0;
  bit sh_x = 1'b0, bl_x = 1'b0;

  initial begin
    shift_rdy = 1'b1;
    blank_rdy = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        sh_cnt = 0; bl_cnt = 0; sh_x = 1'b0; bl_x = 1'b0;
      end else begin
        if (sh_x) sh_cnt = sh_busy; else if (sh_cnt > 0) sh_cnt--;
        if (bl_x) bl_cnt = bl_busy; else if (bl_cnt > 0) bl_cnt--;
      end
      shift_rdy = (sh_cnt == 0) && !sh_hold;
      blank_rdy = (bl_cnt == 0);
      sh_x = rst_n && shift_go && shift_rdy;
      bl_x = rst_n && blank_go && blank_rdy;
    end
  end

  // Scoreboard state: job k is row (k/NP)%NR, plane k%NP.
  int k_sh = 0, k_bl = 0, le_since = 0, fd_cnt = 0;
  bit fd_exp = 1'b0, overlap = 1'b0, rst_seen = 1'b0, was_rst;
  bit p_sgo = 1'b0, p_sx = 1'b0, p_bgo = 1'b0, p_bx = 1'b0, p_le = 1'b0;
  logic [1:0] p_addr = '0, p_row = '0, p_bp = '0;
  logic [0:0] p_pl = '0;
  int lg_srow[$], lg_spl[$], lg_baddr[$], lg_bpl[$];

  initial begin
    bit sx, bx;
    forever begin
      @(negedge clk); #2;
      was_rst  = rst_seen;
      rst_seen = !rst_n;
      if (was_rst)
        chk_eq("reset_outputs", {phy_addr, phy_le, shift_go, shift_row, shift_plane,
                                 blank_go, blank_plane, frame_done}, 0);
      if (!rst_n) begin
        k_sh = 0; k_bl = 0; le_since = 0; fd_exp = 1'b0;
        p_sgo = 1'b0; p_sx = 1'b0; p_bgo = 1'b0; p_bx = 1'b0; p_le = 1'b0;
        p_addr = '0; p_row = '0; p_pl = '0; p_bp = '0;
      end else begin
        if (!was_rst) begin
          chk_eq("frame_done", frame_done, fd_exp);
          if (p_sgo && !p_sx) begin
            chk_eq("shift_go_held", shift_go, 1);
            chk_eq("shift_row_held", shift_row, p_row);
            chk_eq("shift_plane_held", shift_plane, p_pl);
          end
          if (p_bgo && !p_bx) begin
            chk_eq("blank_go_held", blank_go, 1);
            chk_eq("blank_plane_held", blank_plane, p_bp);
          end
          if (p_le) begin
            chk_eq("le_then_blank_go", blank_go, 1);
            chk_eq("le_one_cycle", phy_le, 0);
          end
          if (phy_addr != p_addr) chk_eq("addr_moves_with_le", phy_le, 1);
        end
        if (phy_le) begin
          chk_eq("le_needs_blank_rdy", blank_rdy, 1);
          le_since++;
        end
        if (frame_done) fd_cnt++;
        fd_exp = 1'b0;
        sx = shift_go && shift_rdy;
        bx = blank_go && blank_rdy;
        if (sx) begin
          chk_eq("shift_row", shift_row, (k_sh / NP) % NR);
          chk_eq("shift_plane", shift_plane, k_sh % NP);
          chk_eq("one_job_pending", k_sh, k_bl);
          lg_srow.push_back(int'(shift_row));
          lg_spl.push_back(int'(shift_plane));
          if (!blank_rdy) overlap = 1'b1;
          k_sh++;
        end
        if (bx) begin
          chk_eq("blank_plane", blank_plane, 1 << (k_bl % NP));
          chk_eq("phy_addr", phy_addr, (k_bl / NP) % NR);
          chk_eq("le_per_blank", le_since, 1);
          chk_eq("blank_after_shift", k_sh, k_bl + 1);
          lg_baddr.push_back(int'(phy_addr));
          lg_bpl.push_back(int'(blank_plane));
          fd_exp = ((k_bl % NJ) == NJ - 1);
          le_since = 0;
          k_bl++;
        end
        p_sgo = shift_go; p_sx = sx; p_bgo = blank_go; p_bx = bx; p_le = phy_le;
        p_addr = phy_addr; p_row = shift_row; p_pl = shift_plane; p_bp = blank_plane;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic smp();
    @(negedge clk); #3;
  endtask

  int exp_srow[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_spl[9]   = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int exp_baddr[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int exp_bpl[8]   = '{1, 2, 1, 2, 1, 2, 1, 2};

  initial begin
    int n, bad, s0, b0, f0, lat_sg, lat_le, lat_bg;
    logic [1:0] r0;
    logic [0:0] q0;
    rst_n  = 1'b0;
    enable = 1'b1;

    // Reset held with enable high, then idle with enable low
    repeat (3) @(negedge clk);
    #3 chk_eq("reset_hold_zero", {phy_addr, phy_le, shift_go, shift_row, shift_plane,
                                  blank_go, blank_plane, frame_done}, 0);
    @(negedge clk); rst_n = 1'b1; enable = 1'b0;
    bad = 0;
    repeat (50) begin smp(); if (shift_go || blank_go || phy_le) bad++; end
    chk_eq("idle_no_go", bad, 0);

    // Full frame with 3-cycle responders, latency pinned from the enable edge
    @(negedge clk); enable = 1'b1;
    lat_sg = -1; lat_le = -1; lat_bg = -1;
    for (int i = 1; i <= 20; i++) begin
      smp();
      if (shift_go && lat_sg < 0) lat_sg = i;
      if (phy_le && lat_le < 0) lat_le = i;
      if (blank_go && lat_bg < 0) lat_bg = i;
    end
    chk_eq("lat_enable_to_shift_go", lat_sg, 1);
    chk_eq("lat_enable_to_phy_le", lat_le, 7);
    chk_eq("lat_enable_to_blank_go", lat_bg, 8);
    n = 0;
    while (k_bl < 9 && n < 1000) begin smp(); n++; end
    chk_eq("frame_jobs_done", k_bl >= 9, 1);
    for (int i = 0; i < 9; i++) begin
      chk_eq("log_shift_row", lg_srow[i], exp_srow[i]);
      chk_eq("log_shift_plane", lg_spl[i], exp_spl[i]);
    end
    for (int i = 0; i < 8; i++) begin
      chk_eq("log_phy_addr", lg_baddr[i], exp_baddr[i]);
      chk_eq("log_blank_plane", lg_bpl[i], exp_bpl[i]);
    end
    chk_eq("frame_done_count", fd_cnt, 1);

    // Long display, shorter shift: next shift completes while the display runs
    sh_busy = 5; bl_busy = 40; overlap = 1'b0;
    b0 = k_bl; n = 0;
    while (k_bl < b0 + 3 && n < 600) begin smp(); n++; end
    chk_eq("long_display_progress", k_bl >= b0 + 3, 1);
    chk_eq("shift_during_display", overlap, 1);

    // Stall the shifter in SHIFT_GO for 10 cycles
    sh_busy = 3; bl_busy = 3;
    n = 0;
    while (!phy_le && n < 200) begin smp(); n++; end
    chk_eq("wait_phy_le", phy_le, 1);
    sh_hold = 1'b1; s0 = k_sh;
    n = 0;
    while (!shift_go && n < 50) begin smp(); n++; end
    chk_eq("wait_stalled_go", shift_go, 1);
    r0 = shift_row; q0 = shift_plane; bad = 0;
    repeat (10) begin
      smp();
      if (!shift_go || shift_row != r0 || shift_plane != q0) bad++;
    end
    chk_eq("stall_stable", bad, 0);
    sh_hold = 1'b0;
    n = 0;
    while (shift_go && n < 50) begin smp(); n++; end
    chk_eq("stall_one_transfer", k_sh, s0 + 1);

    // One whole frame of jobs gives exactly one frame_done
    f0 = fd_cnt; b0 = k_bl; n = 0;
    while (k_bl < b0 + NJ && n < 2000) begin smp(); n++; end
    smp();
    chk_eq("frame_done_per_frame", fd_cnt, f0 + 1);

    // Enable drop after a shift transfer: that job still displays, then idle
    n = 0;
    while (!shift_go && n < 200) begin smp(); n++; end
    n = 0;
    while (shift_go && n < 50) begin smp(); n++; end
    enable = 1'b0; s0 = k_sh; b0 = k_bl;
    repeat (150) smp();
    chk_eq("drop_one_more_blank", k_bl, b0 + 1);
    chk_eq("drop_no_more_shift", k_sh, s0);
    chk_eq("drop_idle_go", shift_go || blank_go, 0);
    enable = 1'b1; n = 0;
    while (k_sh <= s0 && n < 100) begin smp(); n++; end
    chk_eq("resume_row", lg_srow[s0], (s0 / NP) % NR);
    chk_eq("resume_plane", lg_spl[s0], s0 % NP);

    // Reset while waiting for the shifter
    n = 0;
    while (!shift_go && n < 200) begin smp(); n++; end
    n = 0;
    while (shift_go && n < 50) begin smp(); n++; end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #3 chk_eq("mid_reset_zero", {phy_addr, phy_le, shift_go, shift_row, shift_plane,
                                 blank_go, blank_plane, frame_done}, 0);
    n = 0;
    while (!shift_go && n < 50) begin smp(); n++; end
    chk_eq("post_reset_go", shift_go, 1);
    chk_eq("post_reset_row", shift_row, 0);
    chk_eq("post_reset_plane", shift_plane, 0);
    n = 0;
    while (k_bl < 2 && n < 200) begin smp(); n++; end
    chk_eq("post_reset_progress", k_bl >= 2, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
